// File: rtl/i2c_slave_shift_engine_pkg.sv
// i2c_slave_shift_engine_pkg: shared slave-side state, address constants and transfer direction
package i2c_slave_shift_engine_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR1,
        ADDR1_ACK,
        ADDR2,
        ADDR2_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } SlaveStateType;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } DataDirection;

    localparam logic [4:0] ADDR10_PREFIX     = 5'b11110;
    localparam logic [7:0] GENERAL_CALL_ADDR = 8'h00;

endpackage

// File: rtl/i2c_slave_shift_engine_slave_bus_monitor.sv
// slave_bus_monitor: SCL edge and START/STOP condition detection on synchronized bus lines
module slave_bus_monitor (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_prev;
    logic sda_prev;

    // Reset to the idle-high bus level so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_in;
            sda_prev <= sda_in;
        end
    end

    assign scl_rise  = scl_in & ~scl_prev;
    assign scl_fall  = ~scl_in & scl_prev;
    assign start_det = scl_in & scl_prev & sda_prev & ~sda_in;
    assign stop_det  = scl_in & scl_prev & ~sda_prev & sda_in;

endmodule

// File: rtl/i2c_slave_shift_engine.sv
// i2c_slave_shift_engine: I2C target byte engine (7/10-bit address match, RX/TX shifting, ACK/NACK).
// Define GENERAL_CALL_EN to also accept the 7-bit general call address 8'h00.
module i2c_slave_shift_engine
    import i2c_slave_shift_engine_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_pull,
    input  logic [ADDR_W-1:0] own_address,
    input  logic              address_mode,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_load,
    input  logic              rx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_strobe,
    output logic              addressed,
    output logic              rw_mode,
    output logic              tx_underrun,
    output logic              bus_busy
);

    SlaveStateType state, state_next;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       done, need_addr2, ten_prev;
    logic [7:0] byte_in, tx_byte;
    logic       last_rise, hdr_match, gc_match, addr1_match, addr2_match, tx_reload;

    slave_bus_monitor u_mon (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign byte_in   = {shreg, sda_in};
    assign tx_byte   = tx_valid ? tx_data : 8'hFF;
    assign last_rise = scl_rise && bit_cnt == 3'd7;
    assign hdr_match = byte_in[7:3] == ADDR10_PREFIX && byte_in[2:1] == own_address[9:8];
`ifdef GENERAL_CALL_EN
    assign gc_match  = byte_in == GENERAL_CALL_ADDR;
`else
    assign gc_match  = 1'b0;
`endif
    // A 10-bit read header only matches after a completed 10-bit write addressing phase
    assign addr1_match = address_mode
        ? (hdr_match && (DataDirection'(byte_in[0]) == DIR_WRITE || ten_prev))
        : (byte_in[7:1] == own_address[6:0] || gc_match);
    assign addr2_match = byte_in == own_address[7:0];
    assign tx_reload   = scl_fall && ((state == ADDR1_ACK && !need_addr2 && DataDirection'(rw_mode) == DIR_READ)
                                      || (state == TX_ACK && done));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start_det) state_next = ADDR1;
        else if (stop_det) state_next = IDLE;
        else begin
            case (state)
                ADDR1:     state_next = (last_rise && !addr1_match) ? WAIT_STOP
                                      : (scl_fall && done) ? ADDR1_ACK : state;
                ADDR1_ACK: state_next = !scl_fall ? state : need_addr2 ? ADDR2
                                      : DataDirection'(rw_mode) == DIR_READ ? TX_BYTE : RX_BYTE;
                ADDR2:     state_next = (last_rise && !addr2_match) ? WAIT_STOP
                                      : (scl_fall && done) ? ADDR2_ACK : state;
                ADDR2_ACK: state_next = scl_fall ? RX_BYTE : state;
                RX_BYTE:   state_next = (scl_fall && done) ? RX_ACK : state;
                RX_ACK:    state_next = scl_fall ? RX_BYTE : state;
                TX_BYTE:   state_next = (scl_fall && bit_cnt == 3'd7) ? TX_ACK : state;
                TX_ACK:    state_next = (scl_rise && sda_in) ? WAIT_STOP
                                      : (scl_fall && done) ? TX_BYTE : state;
                default:   state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= 3'd0;
            shreg       <= 7'd0;
            done        <= 1'b0;
            need_addr2  <= 1'b0;
            ten_prev    <= 1'b0;
            sda_pull    <= 1'b0;
            tx_load     <= 1'b0;
            tx_underrun <= 1'b0;
            rx_data     <= 8'h00;
            rx_strobe   <= 1'b0;
            addressed   <= 1'b0;
            rw_mode     <= 1'b0;
            bus_busy    <= 1'b0;
        end else begin
            rx_strobe   <= 1'b0;
            tx_load     <= 1'b0;
            tx_underrun <= 1'b0;
            if (start_det) begin
                bit_cnt   <= 3'd0;
                done      <= 1'b0;
                sda_pull  <= 1'b0;
                addressed <= 1'b0;
                bus_busy  <= 1'b1;
            end else if (stop_det) begin
                done      <= 1'b0;
                sda_pull  <= 1'b0;
                addressed <= 1'b0;
                bus_busy  <= 1'b0;
                ten_prev  <= 1'b0;
            end else begin
                case (state)
                    ADDR1, ADDR2, RX_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            done    <= bit_cnt == 3'd7;
                        end
                        if (last_rise && state == ADDR1 && addr1_match) begin
                            rw_mode    <= byte_in[0];
                            need_addr2 <= address_mode && !byte_in[0];
                        end
                        if (last_rise && state == ADDR2 && addr2_match) begin
                            rw_mode  <= DIR_WRITE;
                            ten_prev <= 1'b1;
                        end
                        if (last_rise && state == RX_BYTE) begin
                            rx_data   <= byte_in;
                            rx_strobe <= 1'b1;
                        end
                        if (scl_fall && done) begin
                            done     <= 1'b0;
                            sda_pull <= state == RX_BYTE ? rx_ready : 1'b1;
                        end
                    end
                    ADDR1_ACK, ADDR2_ACK, RX_ACK: begin
                        if (scl_fall) begin
                            sda_pull <= 1'b0;
                            bit_cnt  <= 3'd0;
                            if (state == ADDR2_ACK || (state == ADDR1_ACK && !need_addr2)) addressed <= 1'b1;
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            shreg    <= {shreg[5:0], 1'b1};
                            sda_pull <= bit_cnt == 3'd7 ? 1'b0 : ~shreg[6];
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) done <= ~sda_in;
                        if (scl_fall) done <= 1'b0;
                    end
                    default: sda_pull <= 1'b0;
                endcase
                if (tx_reload) begin
                    shreg       <= tx_byte[6:0];
                    sda_pull    <= ~tx_byte[7];
                    tx_load     <= tx_valid;
                    tx_underrun <= ~tx_valid;
                    bit_cnt     <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_shift_engine.sv
// tb_i2c_slave_shift_engine: directed bit-banged I2C master scenarios against the slave engine
module tb_i2c_slave_shift_engine;

    localparam int Q = 2;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_pull;
    logic [9:0] own_address = 10'h02A;
    logic       address_mode = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid = 1'b1;
    logic       tx_load;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       addressed;
    logic       rw_mode;
    logic       tx_underrun;
    logic       bus_busy;

    logic [7:0] tx_q [4];
    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int load_cnt = 0;
    int under_cnt = 0;
    int pull_cnt = 0;

    assign sda_in  = sda_m & ~sda_pull;
    assign tx_data = tx_q[load_cnt[1:0]];

    always #5 clk = ~clk;

    i2c_slave_shift_engine #(.ADDR_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_in      (scl),
        .sda_in      (sda_in),
        .sda_pull    (sda_pull),
        .own_address (own_address),
        .address_mode(address_mode),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_load     (tx_load),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .addressed   (addressed),
        .rw_mode     (rw_mode),
        .tx_underrun (tx_underrun),
        .bus_busy    (bus_busy)
    );

    always @(negedge clk) begin
        if (rx_strobe)   strobe_cnt++;
        if (tx_load)     load_cnt++;
        if (tx_underrun) under_cnt++;
        if (sda_pull)    pull_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; tick(Q);
        scl = 1'b1; tick(H);
        scl = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(H / 2);
        b = sda_in;   tick(H / 2);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(b);
        ack = !b;
    endtask

    task automatic read_byte(output logic [7:0] v, input logic ack);
        for (int i = 7; i >= 0; i--) get_bit(v[i]);
        put_bit(!ack);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(3);
        rst = 1'b0; tick(1);
        tests++; if (sda_pull !== 1'b0)  begin fails++; $display("FAIL reset_sda_pull: got %b want 0", sda_pull); end
        tests++; if (addressed !== 1'b0) begin fails++; $display("FAIL reset_addressed: got %b want 0", addressed); end
        tests++; if (bus_busy !== 1'b0)  begin fails++; $display("FAIL reset_bus_busy: got %b want 0", bus_busy); end
        tests++; if (rw_mode !== 1'b0)   begin fails++; $display("FAIL reset_rw_mode: got %b want 0", rw_mode); end
        tests++; if (rx_data !== 8'h00)  begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    endtask

    task automatic test_write7();
        logic a;
        int s;
        own_address = 10'h02A; address_mode = 1'b0; rx_ready = 1'b1;
        s = strobe_cnt;
        bus_start();
        tests++; if (bus_busy !== 1'b1) begin fails++; $display("FAIL w7_bus_busy: got %b want 1", bus_busy); end
        write_byte(8'h54, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL w7_addr_ack: got %b want 1", a); end
        write_byte(8'hA5, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL w7_data_ack: got %b want 1", a); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL w7_rx_data: got %h want a5", rx_data); end
        tests++; if (strobe_cnt - s !== 1) begin fails++; $display("FAIL w7_strobes: got %0d want 1", strobe_cnt - s); end
        tests++; if (addressed !== 1'b1 || rw_mode !== 1'b0) begin fails++; $display("FAIL w7_addressed_rw: got %b%b want 10", addressed, rw_mode); end
        bus_stop();
        tests++; if (addressed !== 1'b0 || bus_busy !== 1'b0) begin fails++; $display("FAIL w7_after_stop: got %b%b want 00", addressed, bus_busy); end
    endtask

    task automatic test_miss();
        logic a;
        int s, p;
        s = strobe_cnt; p = pull_cnt;
        bus_start();
        write_byte(8'h56, a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL miss_addr_ack: got %b want 0", a); end
        write_byte(8'h12, a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL miss_data_ack: got %b want 0", a); end
        tests++; if (pull_cnt !== p) begin fails++; $display("FAIL miss_pull: got %0d cycles want 0", pull_cnt - p); end
        tests++; if (strobe_cnt !== s || addressed !== 1'b0) begin fails++; $display("FAIL miss_strobe_addr: got %0d/%b want 0/0", strobe_cnt - s, addressed); end
        bus_stop();
    endtask

    task automatic test_read7();
        logic a;
        logic [7:0] v;
        int l, u;
        l = load_cnt; u = under_cnt;
        tx_q[l[1:0]] = 8'hC3; tx_q[2'(l + 1)] = 8'h3C; tx_valid = 1'b1;
        bus_start();
        write_byte(8'h55, a);
        tests++; if (a !== 1'b1 || rw_mode !== 1'b1) begin fails++; $display("FAIL r7_addr: got ack %b rw %b want 1 1", a, rw_mode); end
        read_byte(v, 1'b1);
        tests++; if (v !== 8'hC3) begin fails++; $display("FAIL r7_byte0: got %h want c3", v); end
        read_byte(v, 1'b0);
        tests++; if (v !== 8'h3C) begin fails++; $display("FAIL r7_byte1: got %h want 3c", v); end
        tests++; if (load_cnt - l !== 2 || under_cnt !== u) begin fails++; $display("FAIL r7_loads: got %0d/%0d want 2/0", load_cnt - l, under_cnt - u); end
        tick(4);
        tests++; if (sda_pull !== 1'b0) begin fails++; $display("FAIL r7_released: got %b want 0", sda_pull); end
        bus_stop();
    endtask

    task automatic test_10bit();
        logic a;
        logic [7:0] v;
        int l;
        own_address = 10'h2B4; address_mode = 1'b1;
        l = load_cnt; tx_q[l[1:0]] = 8'h96; tx_valid = 1'b1;
        bus_start();
        write_byte(8'hF4, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL a10_hdr_ack: got %b want 1", a); end
        write_byte(8'hB4, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL a10_low_ack: got %b want 1", a); end
        write_byte(8'h11, a);
        tests++; if (a !== 1'b1 || rx_data !== 8'h11) begin fails++; $display("FAIL a10_data: got ack %b data %h want 1 11", a, rx_data); end
        bus_start();
        write_byte(8'hF5, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL a10_sr_ack: got %b want 1", a); end
        tests++; if (rw_mode !== 1'b1 || addressed !== 1'b1 || load_cnt - l !== 1) begin fails++; $display("FAIL a10_tx_begin: got rw %b addr %b loads %0d want 1 1 1", rw_mode, addressed, load_cnt - l); end
        read_byte(v, 1'b0);
        tests++; if (v !== 8'h96) begin fails++; $display("FAIL a10_tx_byte: got %h want 96", v); end
        bus_stop();
        own_address = 10'h02A; address_mode = 1'b0;
    endtask

    task automatic test_backpressure_underrun();
        logic a;
        logic [7:0] v;
        int l, u;
        rx_ready = 1'b0;
        bus_start();
        write_byte(8'h54, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL bp_addr_ack: got %b want 1", a); end
        write_byte(8'h77, a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL bp_nack: got ack %b want 0", a); end
        tests++; if (rx_data !== 8'h77) begin fails++; $display("FAIL bp_rx_data: got %h want 77", rx_data); end
        bus_stop();
        rx_ready = 1'b1; tx_valid = 1'b0;
        l = load_cnt; u = under_cnt;
        bus_start();
        write_byte(8'h55, a);
        read_byte(v, 1'b0);
        tests++; if (v !== 8'hFF) begin fails++; $display("FAIL ur_byte: got %h want ff", v); end
        tests++; if (under_cnt - u !== 1 || load_cnt !== l) begin fails++; $display("FAIL ur_pulses: got under %0d load %0d want 1 0", under_cnt - u, load_cnt - l); end
        bus_stop();
        tx_valid = 1'b1;
    endtask

    task automatic test_mid_stop();
        logic a;
        int s;
        s = strobe_cnt;
        bus_start();
        write_byte(8'h54, a);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        bus_stop();
        tick(2);
        tests++; if (strobe_cnt !== s) begin fails++; $display("FAIL ms_strobe: got %0d want 0", strobe_cnt - s); end
        tests++; if (bus_busy !== 1'b0 || addressed !== 1'b0) begin fails++; $display("FAIL ms_idle: got busy %b addr %b want 0 0", bus_busy, addressed); end
    endtask

    task automatic test_rst_mid_ack();
        logic a;
        logic [7:0] d;
        d = 8'h5A;
        bus_start();
        write_byte(8'h54, a);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        tests++; if (sda_pull !== 1'b1) begin fails++; $display("FAIL ra_ack_driven: got %b want 1", sda_pull); end
        rst = 1'b1; tick(1);
        tests++; if (sda_pull !== 1'b0) begin fails++; $display("FAIL ra_released: got %b want 0", sda_pull); end
        rst = 1'b0;
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        tests++; if (bus_busy !== 1'b0 || addressed !== 1'b0) begin fails++; $display("FAIL ra_idle: got busy %b addr %b want 0 0", bus_busy, addressed); end
    endtask

    task automatic test_general_call();
        logic a, exp;
`ifdef GENERAL_CALL_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        bus_start();
        write_byte(8'h00, a);
        tests++; if (a !== exp) begin fails++; $display("FAIL gc_ack: got %b want %b", a, exp); end
        bus_stop();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tx_q[i] = 8'h00;
        test_reset();
        test_write7();
        test_miss();
        test_read7();
        test_10bit();
        test_backpressure_underrun();
        test_mid_stop();
        test_rst_mid_ack();
        test_general_call();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
